viterbi_tb_ctrl_322: RTL and testbench

- Traceback sequencer for the (3,2,2) Viterbi decoder (8 trellis states, 2 info bits per trellis step).
- On each traceback request it takes the minimum-metric start state from the traceback decision unit and the newest survivor-memory column address.
- It then walks the survivor memory backwards one column per step and emits decoded bit pairs after a convergence run.
- It sits between the ACS/survivor-memory write side and the decoded-output sink, and owns the survivor-memory read port.

---
 rtl/viterbi_tb_ctrl_322.sv | 187 ++++++++++++++++++
 tb/tb_viterbi_tb_ctrl_322.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_tb_ctrl_322.sv
// ---------------------------------------------------------------------------
// viterbi_tb_ctrl_322
// Traceback sequencer for the (3,2,2) Viterbi decoder: 8 trellis states and
// 2 info bits per trellis step.
//
// A traceback request latches a start state and the newest survivor-memory
// column address. The block then walks the survivor memory backwards, one
// column every two cycles: a read cycle followed by a calc cycle. The last
// OUT_LEN steps emit decoded bit pairs, newest first.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous active-high reset; aborts any traceback
//   tb_start    single-cycle traceback request
//   best_state  start state, sampled when tb_start is accepted
//   wr_ptr      newest survivor column, sampled when tb_start is accepted
//   sm_rd_en    survivor-memory read strobe
//   sm_rd_addr  survivor-memory read address
//   sm_rd_data  survivor column; bits [2s+1:2s] hold the predecessor
//               selector of state s. Valid one cycle after sm_rd_en.
//   dec_valid   dec_bits valid this cycle
//   dec_bits    decoded info bits; holds its value while dec_valid is low
//   dec_last    final decoded pair of a traceback
//   busy        high from the accepted request until tb_done inclusive
//   tb_done     one-cycle pulse when a traceback completes
//   overrun     one-cycle pulse after a tb_start that arrived while busy
//
// Build option
//   TBCTL_ZERO_START_EN  when defined, best_state is ignored and every
//                        traceback starts from state 0 (terminated trellis).
//                        Timing is the same in both builds.
// ---------------------------------------------------------------------------
module viterbi_tb_ctrl_322 #(
    parameter int AW      = 5,
    parameter int TB_LEN  = 16,
    parameter int OUT_LEN = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tb_start,
    input  logic [2:0]    best_state,
    input  logic [AW-1:0] wr_ptr,
    output logic          sm_rd_en,
    output logic [AW-1:0] sm_rd_addr,
    input  logic [15:0]   sm_rd_data,
    output logic          dec_valid,
    output logic [1:0]    dec_bits,
    output logic          dec_last,
    output logic          busy,
    output logic          tb_done,
    output logic          overrun
);

    // The step counter must be able to hold TB_LEN after the final increment.
    localparam int SW = $clog2(TB_LEN + 1);
    localparam logic [SW-1:0] OUT_START = SW'(TB_LEN - OUT_LEN);
    localparam logic [SW-1:0] LAST_STEP = SW'(TB_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_CALC,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [2:0]    cur_state_q;
    logic [AW-1:0] addr_q;
    logic [SW-1:0] step_q;
    logic          rd_en_q;
    logic          dec_valid_q;
    logic [1:0]    dec_bits_q;
    logic          dec_last_q;
    logic          busy_q;
    logic          tb_done_q;
    logic          overrun_q;

    logic [1:0]    sel_arr [8];
    logic [1:0]    sel_d;
    logic [2:0]    cur_state_d;
    logic [AW-1:0] addr_d;
    logic [SW-1:0] step_d;
    logic [2:0]    start_state_d;

    // Split the survivor column into one 2-bit selector per trellis state.
    for (genvar gi = 0; gi < 8; gi++) begin : g_sel
        assign sel_arr[gi] = sm_rd_data[2*gi+1 -: 2];
    end

`ifdef TBCTL_ZERO_START_EN
    logic unused_best_state;
    assign unused_best_state = ^best_state;
    assign start_state_d     = 3'b000;
`else
    assign start_state_d     = best_state;
`endif

    always_comb begin
        sel_d       = sel_arr[cur_state_q];
        // Predecessor: the selector supplies the top two bits, the oldest
        // bit of the current state shifts down into the LSB.
        cur_state_d = {sel_d, cur_state_q[2]};
        // Column address walks backwards and wraps modulo 2^AW.
        addr_d      = addr_q - AW'(1);
        step_d      = step_q + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cur_state_q <= 3'b000;
            addr_q      <= '0;
            step_q      <= '0;
            rd_en_q     <= 1'b0;
            dec_valid_q <= 1'b0;
            dec_bits_q  <= 2'b00;
            dec_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            tb_done_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            // Any request outside IDLE (DONE included) is dropped and flagged.
            overrun_q <= tb_start && (state_q != S_IDLE);

            case (state_q)
                S_IDLE: begin
                    if (tb_start) begin
                        cur_state_q <= start_state_d;
                        addr_q      <= wr_ptr;
                        step_q      <= '0;
                        busy_q      <= 1'b1;
                        rd_en_q     <= 1'b1;
                        state_q     <= S_RD;
                    end
                end

                S_RD: begin
                    // The decoded pair depends only on the current state, so
                    // it is registered here and appears in the calc cycle,
                    // alongside the survivor data for the same step.
                    rd_en_q     <= 1'b0;
                    dec_valid_q <= (step_q >= OUT_START);
                    if (step_q >= OUT_START) begin
                        dec_bits_q <= cur_state_q[1:0];
                    end
                    dec_last_q  <= (step_q == LAST_STEP);
                    state_q     <= S_CALC;
                end

                S_CALC: begin
                    dec_valid_q <= 1'b0;
                    dec_last_q  <= 1'b0;
                    cur_state_q <= cur_state_d;
                    addr_q      <= addr_d;
                    step_q      <= step_d;
                    if (step_q == LAST_STEP) begin
                        tb_done_q <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        rd_en_q   <= 1'b1;
                        state_q   <= S_RD;
                    end
                end

                S_DONE: begin
                    tb_done_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign sm_rd_en   = rd_en_q;
    assign sm_rd_addr = addr_q;
    assign dec_valid  = dec_valid_q;
    assign dec_bits   = dec_bits_q;
    assign dec_last   = dec_last_q;
    assign busy       = busy_q;
    assign tb_done    = tb_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_viterbi_tb_ctrl_322.sv
// ---------------------------------------------------------------------------
// Testbench for viterbi_tb_ctrl_322.
// The stimulus side issues traceback requests and pushes the expected reads,
// decoded pairs, done and overrun pulses (each tagged with its cycle) into
// queues. A monitor on the falling edge pops and compares whenever the DUT
// raises an output. The survivor memory is a small array behind a
// one-cycle registered read port.
// ---------------------------------------------------------------------------
module tb_viterbi_tb_ctrl_322;

    localparam int AW     = 5;
    localparam int TB_LEN = 16;
    localparam int OUT_LEN = 8;
    localparam int DEPTH  = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          tb_start;
    logic [2:0]    best_state;
    logic [AW-1:0] wr_ptr;
    logic          sm_rd_en;
    logic [AW-1:0] sm_rd_addr;
    logic [15:0]   sm_rd_data;
    logic          dec_valid;
    logic [1:0]    dec_bits;
    logic          dec_last;
    logic          busy;
    logic          tb_done;
    logic          overrun;

    always #5 clk = ~clk;

    viterbi_tb_ctrl_322 #(
        .AW      (AW),
        .TB_LEN  (TB_LEN),
        .OUT_LEN (OUT_LEN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tb_start   (tb_start),
        .best_state (best_state),
        .wr_ptr     (wr_ptr),
        .sm_rd_en   (sm_rd_en),
        .sm_rd_addr (sm_rd_addr),
        .sm_rd_data (sm_rd_data),
        .dec_valid  (dec_valid),
        .dec_bits   (dec_bits),
        .dec_last   (dec_last),
        .busy       (busy),
        .tb_done    (tb_done),
        .overrun    (overrun)
    );

    typedef struct {
        int cyc;
        int val;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_start = -1000;
    logic        mon_en = 1'b0;
    logic [15:0] mem [DEPTH];
    exp_t        rd_q[$];
    exp_t        dec_q[$];
    exp_t        done_q[$];
    exp_t        ovr_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Survivor memory: data valid one cycle after the strobe, garbage otherwise.
    always @(posedge clk) begin
        if (sm_rd_en) sm_rd_data <= mem[sm_rd_addr];
        else          sm_rd_data <= 16'($urandom);
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0d exp %0d", name, cyc, got, exp);
        end
    endtask

    function automatic logic model_busy(input int c);
        return (c >= last_start + 1) && (c <= last_start + 2*TB_LEN + 1);
    endfunction

    // Reference walk: plain arithmetic on the trellis rules.
    task automatic model(input int c, input int bs, input int wp);
        int s;
        int a;
        int d;
`ifdef TBCTL_ZERO_START_EN
        s = 0;
`else
        s = bs;
`endif
        for (int k = 0; k < TB_LEN; k++) begin
            a = ((wp - k) % DEPTH + DEPTH) % DEPTH;
            rd_q.push_back('{c + 1 + 2*k, a});
            d = (int'(mem[a]) >> (2*s)) & 3;
            if (k >= TB_LEN - OUT_LEN)
                dec_q.push_back('{c + 2 + 2*k, ((k == TB_LEN-1) ? 4 : 0) + (s % 4)});
            s = d * 2 + s / 4;
        end
        done_q.push_back('{c + 2*TB_LEN + 1, 0});
    endtask

    task automatic issue(input int bs, input int wp);
        int c;
        c = cyc;
        tb_start   = 1'b1;
        best_state = 3'(bs);
        wr_ptr     = AW'(wp);
        if (model_busy(c)) begin
            ovr_q.push_back('{c + 1, 0});
            $display("req cyc=%0d bs=%0d wp=%0d rejected", c, bs, wp);
        end else begin
            model(c, bs, wp);
            last_start = c;
            $display("req cyc=%0d bs=%0d wp=%0d accepted", c, bs, wp);
        end
        @(posedge clk); #1;
        tb_start = 1'b0;
    endtask

    task automatic goto_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle();
        goto_cyc(last_start + 2*TB_LEN + 2);
    endtask

    task automatic fill_mem(input int mode);
        for (int i = 0; i < DEPTH; i++) begin
            case (mode)
                0:       mem[i] = 16'hFFFF;
                1:       mem[i] = 16'h0000;
                default: mem[i] = 16'($urandom);
            endcase
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_en"},     int'(sm_rd_en),   0);
        chk({tag, "_rd_addr"},   int'(sm_rd_addr), 0);
        chk({tag, "_dec_valid"}, int'(dec_valid),  0);
        chk({tag, "_dec_bits"},  int'(dec_bits),   0);
        chk({tag, "_dec_last"},  int'(dec_last),   0);
        chk({tag, "_busy"},      int'(busy),       0);
        chk({tag, "_tb_done"},   int'(tb_done),    0);
        chk({tag, "_overrun"},   int'(overrun),    0);
    endtask

    // Monitor: every raised output must match the head of its queue.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (sm_rd_en) begin
                if (rd_q.size() == 0) begin
                    chk("rd_unexpected", 1, 0);
                end else begin
                    e = rd_q.pop_front();
                    chk("rd_cycle", cyc, e.cyc);
                    chk("rd_addr", int'(sm_rd_addr), e.val);
                end
            end
            if (dec_valid) begin
                $display("dec cyc=%0d bits=%0d last=%0d", cyc, dec_bits, dec_last);
                if (dec_q.size() == 0) begin
                    chk("dec_unexpected", 1, 0);
                end else begin
                    e = dec_q.pop_front();
                    chk("dec_cycle", cyc, e.cyc);
                    chk("dec_last_bits", int'({dec_last, dec_bits}), e.val);
                end
            end else begin
                chk("dec_last_without_valid", int'(dec_last), 0);
            end
            if (tb_done) begin
                $display("done cyc=%0d", cyc);
                if (done_q.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    e = done_q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                end
            end
            if (overrun) begin
                $display("overrun cyc=%0d", cyc);
                if (ovr_q.size() == 0) begin
                    chk("overrun_unexpected", 1, 0);
                end else begin
                    e = ovr_q.pop_front();
                    chk("overrun_cycle", cyc, e.cyc);
                end
            end
            chk("busy", int'(busy), int'(model_busy(cyc)));
        end
    end

    initial begin
        int c0;
        reset      = 1'b1;
        tb_start   = 1'b1;
        best_state = 3'd5;
        wr_ptr     = AW'(7);
        sm_rd_data = 16'h0000;
        fill_mem(2);

        // Reset held three cycles with a pending request.
        repeat (3) begin
            @(posedge clk); #1;
            chk_all_zero("reset");
        end
        reset    = 1'b0;
        tb_start = 1'b0;
        mon_en   = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("post_reset");

        // Basic traceback: all-ones memory, start state 5.
        fill_mem(0);
        issue(5, 3);
        wait_idle();

        // All-zero memory from state 6.
        fill_mem(1);
        issue(6, 10);
        wait_idle();

        // Terminated-trellis style stimulus: best_state 7, zero memory.
        issue(7, 0);
        wait_idle();

        // Overrun: early request, request in DONE cycle, then accepted one.
        fill_mem(2);
        c0 = cyc;
        issue($urandom_range(0, 7), $urandom_range(0, DEPTH-1));
        goto_cyc(c0 + 5);
        issue($urandom_range(0, 7), $urandom_range(0, DEPTH-1));
        goto_cyc(c0 + 2*TB_LEN + 1);
        issue($urandom_range(0, 7), $urandom_range(0, DEPTH-1));
        chk("accept_after_done_cycle", cyc, c0 + 2*TB_LEN + 2);
        issue($urandom_range(0, 7), $urandom_range(0, DEPTH-1));
        chk("accepted_start", last_start, c0 + 2*TB_LEN + 2);
        wait_idle();

        // Abort during the third calc cycle.
        fill_mem(2);
        c0 = cyc;
        issue($urandom_range(0, 7), $urandom_range(0, DEPTH-1));
        goto_cyc(c0 + 6);
        reset = 1'b1;
        rd_q.delete();
        dec_q.delete();
        done_q.delete();
        @(posedge clk); #1;
        reset      = 1'b0;
        last_start = -1000;
        chk_all_zero("abort");
        issue($urandom_range(0, 7), $urandom_range(0, DEPTH-1));
        wait_idle();

        // Randomized tracebacks with occasional overlapping requests.
        for (int n = 0; n < 30; n++) begin
            fill_mem(2);
            issue($urandom_range(0, 7), $urandom_range(0, DEPTH-1));
            if ($urandom_range(0, 2) == 0) begin
                goto_cyc(last_start + $urandom_range(1, 2*TB_LEN + 1));
                issue($urandom_range(0, 7), $urandom_range(0, DEPTH-1));
            end
            wait_idle();
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
        end

        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("rd_queue_left",   rd_q.size(),   0);
        chk("dec_queue_left",  dec_q.size(),  0);
        chk("done_queue_left", done_q.size(), 0);
        chk("ovr_queue_left",  ovr_q.size(),  0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
